echo_requester: RTL and testbench
=================================

Name: echo_requester

Overview:
- Initiator/consumer end of the echo protocol.
- Issues a programmed sequence of echoReq calls toward an echo server and implements the echo indication method the server calls back.
- Keeps an in-order scoreboard of outstanding request values, checks every returned value and counts mismatches.
- Reports completion upward through a done indication.
- Sits beside the echo server as its test/driver peer in loopback and bring-up builds.

Parameters:
- DEPTH, 4: maximum outstanding requests (scoreboard entries); power of two, minimum 2.
- STRIDE, 1: 32-bit increment between successive request values.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- start__ENA  in  1  begin a run; only asserted while start__RDY=1
- start_count  in  16  number of requests in the run
- start_seed  in  32  first request value
- start__RDY  out  1  high in IDLE only
- echoReq__ENA  out  1  call to server's echoReq
- echoReq_v  out  32  request value
- echoReq__RDY  in  1  server can accept echoReq
- echo__ENA  in  1  server's echo indication; only asserted while echo__RDY=1
- echo_v  in  32  returned value
- echo__RDY  out  1  requester can accept an echo
- done__ENA  out  1  run-complete indication
- done_errors  out  16  mismatch count for the run
- done_first_bad  out  32  first mismatching returned value (0 if none)
- done__RDY  in  1  upstream accepts done

Behaviour:
- Method rule: an action occurs in the cycle where ENA=1, and ENA is asserted only while the matching RDY=1. Every state update is on posedge CLK.
- Reset (RST=1 at posedge):
  - state=IDLE; sent, received, outstanding, errors, wr/rd pointers cleared to 0.
  - first_bad=0, next_v=0.
  - Consequently echoReq__ENA=0, echo__RDY=0, done__ENA=0 and start__RDY=1 from the first cycle after reset.
  - Reset mid-run abandons all outstanding entries. Echoes arriving later stall, since echo__RDY=0 outside RUN.
- States:
  - IDLE: start__RDY=1. On start__ENA, latch count and next_v=start_seed, clear counters and first_bad. Next state is RUN if count>0, else DONE.
  - RUN: issue and check. Go to DONE in the cycle received reaches count; the accepted echo in that cycle counts.
  - DONE: done__ENA=1 with done_errors and done_first_bad held stable. On done__RDY, go to IDLE. A zero-count run goes straight to DONE with errors=0.
- Issue, combinational: echoReq__ENA = RUN & (sent<count) & (outstanding<DEPTH) & echoReq__RDY.
  - echoReq_v = next_v.
  - On issue: scoreboard[wr]=next_v; wr++; sent++; next_v += STRIDE (mod 2^32 wrap).
- Receive: echo__RDY = RUN & (outstanding>0).
  - On echo__ENA: compare echo_v with scoreboard[rd]; rd++; received++.
  - On mismatch: errors++ (saturating at 16'hFFFF). first_bad=echo_v only if this is the first mismatch of the run.
- Outstanding count:
  - Simultaneous issue and receive leaves outstanding unchanged; ±1 otherwise.
  - The issue gate uses the registered outstanding, so no same-cycle bypass: at outstanding==DEPTH no issue occurs even if an echo is accepted that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Scoreboard never overflows or underflows by construction.
- Latency:
  - First echoReq__ENA can assert in the cycle after start is accepted.
  - Echo-accept to done__ENA is 1 cycle, for the final echo.
- start__ENA outside IDLE is illegal. Assert in simulation; RTL ignores it.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DONE)
  - COUNT_W=16, DATA_W=32
  - method-handshake typedef (ENA/RDY pair) reused by the echo server side
- One sub-module: echo_scoreboard. DEPTH-entry in-order FIFO with push, pop, head, count and registered storage. The top holds the FSM, counters and compare.

Test Plan:
- Ideal server (echoReq__RDY=1, echo within 2 cycles, echo_v=request): start_count=5, start_seed=32'h10 → requests 0x10..0x14, done__ENA with done_errors=0, done_first_bad=0.
- Server never answers, echoReq__RDY=1, DEPTH=4, count=10 → exactly 4 echoReq__ENA pulses, then echoReq__ENA stays 0; start__RDY=0 throughout.
- Server corrupts 3rd and 5th replies (seed 0, returns 0xDEAD then 0xBEEF), count=6 → done_errors=2, done_first_bad=32'hDEAD.
- Wrap: seed=32'hFFFF_FFFE, count=4, STRIDE=1 → values FFFFFFFE, FFFFFFFF, 0, 1; no errors.
- start_count=0 → DONE the cycle after start with done_errors=0; done__RDY held 0 for 3 cycles keeps done__ENA and outputs stable; IDLE after done__RDY.
- RST pulsed with 2 outstanding, then a late echo presented → echo__RDY=0, no counter change, start__RDY=1 next cycle; a new run completes cleanly.

Source files
------------

// File: rtl/echo_requester_pkg.sv
// Shared types and widths for the echo requester and its echo server peer.
package echo_requester_pkg;

    localparam int COUNT_W = 16;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ENA/RDY pair of one method call.
    typedef struct packed {
        logic ena;
        logic rdy;
    } method_hs_t;

endpackage

// File: rtl/echo_requester_if.sv
// Echo protocol channel: echoReq calls toward the server, echo indications back.
interface echo_requester_if
    import echo_requester_pkg::*;
();

    logic              echoReq__ENA;
    logic [DATA_W-1:0] echoReq_v;
    logic              echoReq__RDY;
    logic              echo__ENA;
    logic [DATA_W-1:0] echo_v;
    logic              echo__RDY;

    modport master (
        output echoReq__ENA,
        output echoReq_v,
        input  echoReq__RDY,
        input  echo__ENA,
        input  echo_v,
        output echo__RDY
    );

    modport slave (
        input  echoReq__ENA,
        input  echoReq_v,
        output echoReq__RDY,
        output echo__ENA,
        output echo_v,
        input  echo__RDY
    );

endinterface

// File: rtl/echo_requester_scoreboard.sv
// In-order FIFO of outstanding request values; head is the value the next echo must match.
module echo_scoreboard
    import echo_requester_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/echo_requester.sv
// Echo protocol initiator: issues a seeded request sequence, checks echoes in order, reports errors.
//   state   | meaning
//   ST_IDLE | waiting for start, start__RDY high
//   ST_RUN  | issuing echoReq calls and checking returned echoes
//   ST_DONE | done__ENA high with results held until done__RDY
module echo_requester
    import echo_requester_pkg::*;
#(
    parameter int                DEPTH  = 4,
    parameter logic [DATA_W-1:0] STRIDE = 32'd1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start__ENA,
    input  logic [COUNT_W-1:0] start_count,
    input  logic [DATA_W-1:0]  start_seed,
    output logic               start__RDY,
    echo_requester_if.master   srv,
    output logic               done__ENA,
    output logic [COUNT_W-1:0] done_errors,
    output logic [DATA_W-1:0]  done_first_bad,
    input  logic               done__RDY
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, sent_q, recv_q, errors_q;
    logic [DATA_W-1:0]  next_v_q, first_bad_q, sb_head;
    logic [CNT_W-1:0]   outstanding;
    logic               start_acc, issue, accept, mismatch, last_recv;

    assign start_acc = start__ENA && (state_q == ST_IDLE);
    // Registered outstanding only: a full scoreboard blocks issue even if an echo drains it this cycle.
    assign issue     = (state_q == ST_RUN) && (sent_q < count_q) &&
                       (outstanding < DEPTH_C) && srv.echoReq__RDY;
    assign accept    = srv.echo__ENA && srv.echo__RDY;
    assign mismatch  = accept && (srv.echo_v != sb_head);
    assign last_recv = accept && ((recv_q + 1'b1) == count_q);

    assign srv.echoReq__ENA = issue;
    assign srv.echoReq_v    = next_v_q;
    assign srv.echo__RDY    = (state_q == ST_RUN) && (outstanding != '0);

    assign done_errors    = errors_q;
    assign done_first_bad = first_bad_q;

    echo_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .push      (issue),
        .push_data (next_v_q),
        .pop       (accept),
        .head      (sb_head),
        .count     (outstanding)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start__RDY = 1'b0;
        done__ENA  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start__RDY = 1'b1;
                if (start__ENA)
                    state_d = (start_count == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_recv) state_d = ST_DONE;
            end
            ST_DONE: begin
                done__ENA = 1'b1;
                if (done__RDY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q     <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            errors_q    <= '0;
            first_bad_q <= '0;
            next_v_q    <= '0;
        end else if (start_acc) begin
            count_q     <= start_count;
            sent_q      <= '0;
            recv_q      <= '0;
            errors_q    <= '0;
            first_bad_q <= '0;
            next_v_q    <= start_seed;
        end else begin
            if (issue) begin
                sent_q   <= sent_q + 1'b1;
                next_v_q <= next_v_q + STRIDE;
            end
            if (accept) recv_q <= recv_q + 1'b1;
            if (mismatch) begin
                if (errors_q != '1) errors_q <= errors_q + 1'b1;
                if (errors_q == '0) first_bad_q <= srv.echo_v;
            end
        end
    end

    always @(posedge CLK) begin
        if (!RST && start__ENA)
            assert (state_q == ST_IDLE);
    end

endmodule

// File: tb/tb_echo_requester.sv
// Directed bench for echo_requester with a behavioural echo server peer.
module tb_echo_requester;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start__ENA = 1'b0;
    logic [15:0] start_count = '0;
    logic [31:0] start_seed = '0;
    logic        start__RDY;
    logic        done__ENA;
    logic [15:0] done_errors;
    logic [31:0] done_first_bad;
    logic        done__RDY = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_issue = 0;
    int n_reply = 0;
    int last_acc_cyc = -1;
    logic [31:0] srv_q[$];
    logic [31:0] req_log[$];
    bit srv_reply_en = 1'b0;
    bit srv_corrupt = 1'b0;
    bit srv_force_ena = 1'b0;
    bit srv_flush = 1'b0;

    echo_requester_if srv_if();

    echo_requester #(.DEPTH(4), .STRIDE(32'd1)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start__ENA     (start__ENA),
        .start_count    (start_count),
        .start_seed     (start_seed),
        .start__RDY     (start__RDY),
        .srv            (srv_if),
        .done__ENA      (done__ENA),
        .done_errors    (done_errors),
        .done_first_bad (done_first_bad),
        .done__RDY      (done__RDY)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) cyc++;

    // Server peer: log issued requests at the edge, present the next echo just after it.
    initial begin
        srv_if.echo__ENA = 1'b0;
        srv_if.echo_v    = '0;
        forever begin
            @(posedge CLK);
            if (srv_flush) begin
                srv_q.delete();
                req_log.delete();
                n_issue = 0;
                n_reply = 0;
            end else begin
                if (srv_if.echoReq__ENA === 1'b1) begin
                    srv_q.push_back(srv_if.echoReq_v);
                    req_log.push_back(srv_if.echoReq_v);
                    n_issue++;
                end
                if (srv_if.echo__ENA === 1'b1 && srv_if.echo__RDY === 1'b1) begin
                    if (srv_q.size() > 0) void'(srv_q.pop_front());
                    n_reply++;
                    last_acc_cyc = cyc;
                end
            end
            #1;
            if (srv_force_ena) begin
                srv_if.echo__ENA = 1'b1;
                srv_if.echo_v    = 32'h5555_5555;
            end else if (srv_reply_en && srv_q.size() > 0 && srv_if.echo__RDY === 1'b1) begin
                srv_if.echo__ENA = 1'b1;
                srv_if.echo_v    = srv_q[0];
                if (srv_corrupt && n_reply == 2)      srv_if.echo_v = 32'hDEAD;
                else if (srv_corrupt && n_reply == 4) srv_if.echo_v = 32'hBEEF;
            end else begin
                srv_if.echo__ENA = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic start_run(input logic [15:0] cnt, input logic [31:0] seed);
        srv_flush = 1'b1;
        tick();
        srv_flush = 1'b0;
        start_count = cnt;
        start_seed  = seed;
        start__ENA  = 1'b1;
        tick();
        start__ENA  = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done__ENA === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic ack_done();
        done__RDY = 1'b1;
        tick();
        done__RDY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        srv_if.echoReq__RDY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        checks++;
        if (start__RDY !== 1'b1) begin failures++; $display("FAIL reset_start_rdy got=%b exp=1", start__RDY); end
        checks++;
        if (srv_if.echoReq__ENA !== 1'b0 || srv_if.echo__RDY !== 1'b0 || done__ENA !== 1'b0) begin
            failures++;
            $display("FAIL reset_enables got req=%b echo_rdy=%b done=%b exp=0,0,0",
                     srv_if.echoReq__ENA, srv_if.echo__RDY, done__ENA);
        end
        checks++;
        if (done_errors !== 16'd0 || done_first_bad !== 32'd0) begin
            failures++;
            $display("FAIL reset_results got errors=%h first_bad=%h exp=0,0", done_errors, done_first_bad);
        end
    endtask

    task automatic test_ideal();
        bit ok;
        srv_reply_en = 1'b1;
        srv_corrupt  = 1'b0;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd5, 32'h10);
        checks++;
        if (srv_if.echoReq__ENA !== 1'b1 || srv_if.echoReq_v !== 32'h10) begin
            failures++;
            $display("FAIL ideal_first_issue got ena=%b v=%h exp=1,00000010", srv_if.echoReq__ENA, srv_if.echoReq_v);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ideal_done_timeout got no done exp=done within 100 cycles"); end
        checks++;
        if (last_acc_cyc !== cyc) begin
            failures++;
            $display("FAIL ideal_done_latency got accept_cyc=%0d done_cyc=%0d exp=equal", last_acc_cyc, cyc);
        end
        checks++;
        if (req_log.size() != 5) begin
            failures++;
            $display("FAIL ideal_req_count got=%0d exp=5", req_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (req_log[i] !== 32'h10 + i) begin
                    failures++;
                    $display("FAIL ideal_req_value[%0d] got=%h exp=%h", i, req_log[i], 32'h10 + i);
                end
            end
        end
        checks++;
        if (done_errors !== 16'd0 || done_first_bad !== 32'd0) begin
            failures++;
            $display("FAIL ideal_results got errors=%h first_bad=%h exp=0,0", done_errors, done_first_bad);
        end
        ack_done();
        checks++;
        if (start__RDY !== 1'b1 || done__ENA !== 1'b0) begin
            failures++;
            $display("FAIL ideal_back_to_idle got start_rdy=%b done=%b exp=1,0", start__RDY, done__ENA);
        end
    endtask

    task automatic test_stall();
        bit bad_rdy;
        srv_reply_en = 1'b0;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd10, 32'h100);
        bad_rdy = 1'b0;
        repeat (20) begin
            if (start__RDY !== 1'b0) bad_rdy = 1'b1;
            tick();
        end
        checks++;
        if (n_issue != 4) begin failures++; $display("FAIL stall_issue_count got=%0d exp=4", n_issue); end
        checks++;
        if (srv_if.echoReq__ENA !== 1'b0) begin
            failures++;
            $display("FAIL stall_req_ena got=%b exp=0", srv_if.echoReq__ENA);
        end
        checks++;
        if (bad_rdy) begin failures++; $display("FAIL stall_start_rdy got=1 during run exp=0"); end
        checks++;
        if (srv_if.echo__RDY !== 1'b1) begin
            failures++;
            $display("FAIL stall_echo_rdy got=%b exp=1", srv_if.echo__RDY);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (start__RDY !== 1'b1) begin failures++; $display("FAIL stall_recover got start_rdy=%b exp=1", start__RDY); end
    endtask

    task automatic test_corrupt();
        bit ok;
        srv_reply_en = 1'b1;
        srv_corrupt  = 1'b1;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd6, 32'h0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL corrupt_done_timeout got no done exp=done within 100 cycles"); end
        checks++;
        if (done_errors !== 16'd2) begin failures++; $display("FAIL corrupt_errors got=%h exp=0002", done_errors); end
        checks++;
        if (done_first_bad !== 32'hDEAD) begin
            failures++;
            $display("FAIL corrupt_first_bad got=%h exp=0000dead", done_first_bad);
        end
        checks++;
        if (n_reply != 6) begin failures++; $display("FAIL corrupt_replies got=%0d exp=6", n_reply); end
        ack_done();
        srv_corrupt = 1'b0;
    endtask

    task automatic test_zero_count();
        bit unstable;
        srv_reply_en = 1'b1;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd0, 32'h1234);
        checks++;
        if (done__ENA !== 1'b1 || done_errors !== 16'd0 || done_first_bad !== 32'd0) begin
            failures++;
            $display("FAIL zero_done got done=%b errors=%h first_bad=%h exp=1,0,0",
                     done__ENA, done_errors, done_first_bad);
        end
        checks++;
        if (srv_if.echoReq__ENA !== 1'b0) begin
            failures++;
            $display("FAIL zero_no_issue got=%b exp=0", srv_if.echoReq__ENA);
        end
        unstable = 1'b0;
        repeat (3) begin
            tick();
            if (done__ENA !== 1'b1 || done_errors !== 16'd0 || done_first_bad !== 32'd0) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin failures++; $display("FAIL zero_hold got unstable done outputs exp=held"); end
        ack_done();
        checks++;
        if (start__RDY !== 1'b1 || done__ENA !== 1'b0) begin
            failures++;
            $display("FAIL zero_to_idle got start_rdy=%b done=%b exp=1,0", start__RDY, done__ENA);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'hFFFF_FFFE;
        exp_v[1] = 32'hFFFF_FFFF;
        exp_v[2] = 32'h0000_0000;
        exp_v[3] = 32'h0000_0001;
        srv_reply_en = 1'b1;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd4, 32'hFFFF_FFFE);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_done_timeout got no done exp=done within 100 cycles"); end
        checks++;
        if (req_log.size() != 4) begin
            failures++;
            $display("FAIL wrap_req_count got=%0d exp=4", req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_log[i] !== exp_v[i]) begin
                    failures++;
                    $display("FAIL wrap_req_value[%0d] got=%h exp=%h", i, req_log[i], exp_v[i]);
                end
            end
        end
        checks++;
        if (done_errors !== 16'd0) begin failures++; $display("FAIL wrap_errors got=%h exp=0000", done_errors); end
        ack_done();
    endtask

    task automatic test_reset_midrun();
        bit ok;
        bit bad;
        srv_reply_en = 1'b0;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd5, 32'h40);
        for (int i = 0; i < 20 && n_issue < 2; i++) tick();
        srv_if.echoReq__RDY = 1'b0;
        tick();
        checks++;
        if (n_issue != 2 || srv_if.echo__RDY !== 1'b1) begin
            failures++;
            $display("FAIL midrun_setup got issued=%0d echo_rdy=%b exp=2,1", n_issue, srv_if.echo__RDY);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (start__RDY !== 1'b1 || srv_if.echo__RDY !== 1'b0) begin
            failures++;
            $display("FAIL midrun_after_reset got start_rdy=%b echo_rdy=%b exp=1,0", start__RDY, srv_if.echo__RDY);
        end
        srv_force_ena = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (srv_if.echo__RDY !== 1'b0 || start__RDY !== 1'b1 || done__ENA !== 1'b0) bad = 1'b1;
        end
        srv_force_ena = 1'b0;
        tick();
        checks++;
        if (bad) begin failures++; $display("FAIL midrun_late_echo got echo accepted or state moved exp=stalled in idle"); end
        checks++;
        if (srv_q.size() != 2) begin failures++; $display("FAIL midrun_stale_held got=%0d exp=2", srv_q.size()); end
        srv_reply_en = 1'b1;
        srv_if.echoReq__RDY = 1'b1;
        start_run(16'd3, 32'h70);
        wait_done(ok);
        checks++;
        if (!ok || done_errors !== 16'd0 || done_first_bad !== 32'd0) begin
            failures++;
            $display("FAIL midrun_new_run got ok=%b errors=%h first_bad=%h exp=1,0,0", ok, done_errors, done_first_bad);
        end
        checks++;
        if (req_log.size() != 3 || req_log[0] !== 32'h70) begin
            failures++;
            $display("FAIL midrun_new_values got count=%0d exp=3 first=70", req_log.size());
        end
        ack_done();
    endtask

    initial begin
        srv_if.echoReq__RDY = 1'b0;
        test_reset();
        test_ideal();
        test_stall();
        test_corrupt();
        test_zero_count();
        test_wrap();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
